// File: rtl/input_debouncer.sv
// Multi-channel input debouncer: 2-flop synchronizer plus a per-channel
// stability counter that commits a new level after STABLE qualifying samples.
module input_debouncer #(
    parameter int CHANNELS   = 2,
    parameter int STABLE     = 16,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                busy
);

    localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE - 1);

    logic [CHANNELS-1:0]         s1_q, s2_q;
    logic [CHANNELS-1:0]         out_q, out_d;
    logic [CHANNELS-1:0]         rise_q, rise_d;
    logic [CHANNELS-1:0]         fall_q, fall_d;
    logic [CHANNELS-1:0][CW-1:0] cnt_q, cnt_d;

    // A matching sample always clears progress; tick only gates advancement.
    always_comb begin
        out_d  = out_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (s2_q[ch] == out_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (tick) begin
                if (cnt_q[ch] == CNT_MAX) begin
                    out_d[ch]  = s2_q[ch];
                    cnt_d[ch]  = '0;
                    rise_d[ch] = s2_q[ch];
                    fall_d[ch] = ~s2_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= {CHANNELS{IDLE_LEVEL}};
            s2_q   <= {CHANNELS{IDLE_LEVEL}};
            out_q  <= {CHANNELS{IDLE_LEVEL}};
            cnt_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            s1_q   <= in;
            s2_q   <= s1_q;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            busy = busy | (cnt_q[ch] != '0);
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: a STABLE=4 two-channel instance and a
// STABLE=1 single-channel instance share clock and reset.
module tb_input_debouncer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick  = 1'b1;
    logic [1:0] din   = 2'b11;
    logic [1:0] dout, drise, dfall;
    logic       dbusy;
    logic       din1  = 1'b1;
    logic       dout1, drise1, dfall1, dbusy1;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int c0;

    typedef struct {
        int         cyc;
        string      tag;
        bit         u;
        logic [1:0] o;
        logic [1:0] r;
        logic [1:0] f;
        logic       b;
    } ent_t;

    ent_t sb[$];
    ent_t e_m;

    input_debouncer #(.CHANNELS(2), .STABLE(4), .IDLE_LEVEL(1'b1)) dut (
        .clk(clk), .reset(rst_n), .tick(tick), .in(din),
        .out(dout), .rise(drise), .fall(dfall), .busy(dbusy)
    );

    input_debouncer #(.CHANNELS(1), .STABLE(1), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .reset(rst_n), .tick(1'b1), .in(din1),
        .out(dout1), .rise(drise1), .fall(dfall1), .busy(dbusy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic push(input int d, input string tag, input bit u,
                        input logic [1:0] o, input logic [1:0] r,
                        input logic [1:0] f, input logic b);
        ent_t e;
        e.cyc = cyc + d;
        e.tag = tag;
        e.u   = u;
        e.o   = o;
        e.r   = r;
        e.f   = f;
        e.b   = b;
        sb.push_back(e);
    endtask

    // Edge 0 is the first edge after the input change; new level lands at edge STABLE+1.
    task automatic std_change(input string tag, input logic [1:0] o_old, input logic [1:0] o_new);
        for (int d = 1; d <= 5; d++) push(d, tag, 1'b0, o_old, 2'b00, 2'b00, d >= 3);
        push(6, tag, 1'b0, o_new, o_new & ~o_old, ~o_new & o_old, 1'b0);
        push(7, tag, 1'b0, o_new, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (sb.size() != 0) begin
            check("drain", sb.size(), 0);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e_m = sb.pop_front();
            if (e_m.cyc != cyc) begin
                check($sformatf("%s_late", e_m.tag), cyc, e_m.cyc);
            end else if (!e_m.u) begin
                check($sformatf("%s_out", e_m.tag),  {30'd0, dout},  {30'd0, e_m.o});
                check($sformatf("%s_rise", e_m.tag), {30'd0, drise}, {30'd0, e_m.r});
                check($sformatf("%s_fall", e_m.tag), {30'd0, dfall}, {30'd0, e_m.f});
                check($sformatf("%s_busy", e_m.tag), {31'd0, dbusy}, {31'd0, e_m.b});
            end else begin
                check($sformatf("%s_out", e_m.tag),  {31'd0, dout1},  {31'd0, e_m.o[0]});
                check($sformatf("%s_rise", e_m.tag), {31'd0, drise1}, {31'd0, e_m.r[0]});
                check($sformatf("%s_fall", e_m.tag), {31'd0, dfall1}, {31'd0, e_m.f[0]});
                check($sformatf("%s_busy", e_m.tag), {31'd0, dbusy1}, {31'd0, e_m.b});
            end
        end
    end

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst_out", {30'd0, dout}, 32'h3);
        check("rst_rise", {30'd0, drise}, 32'h0);
        check("rst_fall", {30'd0, dfall}, 32'h0);
        check("rst_busy", {31'd0, dbusy}, 32'h0);
        check("rst_out1", {31'd0, dout1}, 32'h1);
        repeat (2) sync();
        rst_n = 1'b1;
        for (int d = 1; d <= 3; d++) push(d, "release", 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        drain();

        // Single channel falls, other untouched.
        sync(); din = 2'b10; std_change("ch0_fall", 2'b11, 2'b10); drain();
        sync(); din = 2'b11; std_change("ch0_rise", 2'b10, 2'b11); drain();

        // Three-sample glitch must be swallowed.
        sync(); din = 2'b10;
        for (int d = 1; d <= 8; d++)
            push(d, "glitch", 1'b0, 2'b11, 2'b00, 2'b00, (d >= 3 && d <= 5));
        repeat (3) sync();
        din = 2'b11;
        drain();

        // Simultaneous transitions.
        sync(); din = 2'b00; std_change("both_fall", 2'b11, 2'b00); drain();
        sync(); din = 2'b11; std_change("both_rise", 2'b00, 2'b11); drain();

        // Tick every third clock: out[1] moves on the fourth qualifying tick.
        sync(); din = 2'b01;
        for (int d = 1; d <= 11; d++)
            push(d, "tick3", 1'b0, 2'b11, 2'b00, 2'b00, d >= 3);
        push(12, "tick3", 1'b0, 2'b01, 2'b00, 2'b10, 1'b0);
        push(13, "tick3", 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            tick = (k % 3 == 0);
            sync();
        end
        tick = 1'b1;
        drain();
        sync(); din = 2'b11; std_change("tick3_back", 2'b01, 2'b11); drain();

        // Reset mid-count discards progress; counting restarts after release.
        sync(); din = 2'b10;
        for (int d = 1; d <= 4; d++) push(d, "pre_rst", 1'b0, 2'b11, 2'b00, 2'b00, d >= 3);
        repeat (4) sync();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out", {30'd0, dout}, 32'h3);
        check("midrst_busy", {31'd0, dbusy}, 32'h0);
        check("midrst_fall", {30'd0, dfall}, 32'h0);
        sync();
        rst_n = 1'b1;
        std_change("post_rst", 2'b11, 2'b10);
        drain();
        sync(); din = 2'b11; std_change("post_rst_back", 2'b10, 2'b11); drain();

        // STABLE=1 instance tracks its input with a fixed short delay.
        sync();
        c0 = cyc;
        for (int d = 1; d <= 10; d++) begin
            int  j, jp;
            logic o, op;
            j  = d - 3;
            jp = d - 4;
            o  = (j < 0 || j >= 6) ? 1'b1 : logic'((j / 2) % 2);
            op = (jp < 0 || jp >= 6) ? 1'b1 : logic'((jp / 2) % 2);
            push(d, "stable1", 1'b1, {1'b0, o}, {1'b0, o & ~op}, {1'b0, ~o & op}, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            din1 = (k % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) sync();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=finished", cyc);
        $fatal(1);
    end

endmodule
